exe_stage_mc: RTL and testbench
===============================

EXE_STAGE_MC -- requirements
Module: exe_stage_mc

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width in bits (legal 8..64, even).
REQ-002 SHALL have parameter NFWD, default 2, number of forwarding sources (legal 1..7); SW = $clog2(NFWD+1).
REQ-003 SHALL have port clk  in  1  rising-edge clock; one clock domain.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  in  1  upstream holds a valid op.
REQ-006 SHALL have port in_ready  out  1  stage accepts an op this cycle.
REQ-007 SHALL have port op  in  4  op[3]=0: ALU, op[2:0] = alu_ops (add,sll,sra,sub,xor,srl,or,and); op[3]=1: MUL, op[1:0] = mul/mulh/mulhsu/mulhu.
REQ-008 SHALL have port cmpop  in  3  branch_funct3 compare code.
REQ-009 SHALL have ports rs1_sel, rs2_sel  in  SW  operand source: 0 = regfile, k (1..NFWD) = fwd_data slice k-1.
REQ-010 SHALL have ports alumux1_sel  in  1  (0 rs1, 1 pc); alumux2_sel  in  1  (0 imm, 1 rs2); cmp_sel  in  1  (0 rs2, 1 imm).
REQ-011 SHALL have ports rs1_data, rs2_data, pc, imm  in  XLEN each; fwd_data  in  NFWD*XLEN, slice k at [k*XLEN +: XLEN].
REQ-012 SHALL have port flush  in  1  synchronous kill of held or in-flight op.
REQ-013 SHALL have ports out_valid out 1; out_ready in 1; alu_out out XLEN; rs2_out out XLEN (forwarded rs2); br_en out 1; busy out 1 (MUL iterating).

Function
REQ-014 SHALL implement FSM IDLE, BUSY, VALID.
REQ-015 SHALL drive in_ready = !flush & (IDLE | (VALID & out_ready)); accept = in_valid & in_ready.
REQ-016 SHALL resolve forwarding and all muxes combinationally at accept; rs*_sel > NFWD selects regfile.
REQ-017 ALU accept at cycle t SHALL register alu_out, rs2_out, br_en and enter VALID; out_valid=1 at t+1.
REQ-018 MUL accept at t SHALL enter BUSY, run radix-2 shift-add on operand magnitudes, one bit per cycle, XLEN iterations; out_valid=1 exactly at t+XLEN+1.
REQ-019 MUL signedness: mulh both signed, mulhsu rs1 signed/rs2 unsigned, mulhu both unsigned; sign fix by 2*XLEN two's-complement negate; mul returns low XLEN, mulh* high XLEN.
REQ-020 MUL SHALL use rs1/rs2 forwarded operands irrespective of alumux selects; br_en=0 for MUL.
REQ-021 ALU shifts SHALL use b[$clog2(XLEN)-1:0]; sra arithmetic; add/sub wrap modulo 2^XLEN.
REQ-022 br_en SHALL follow cmpop: beq,bne,blt,bge signed; bltu,bgeu unsigned; reserved codes give 0.
REQ-023 In VALID, alu_out/rs2_out/br_en SHALL hold stable while out_ready=0.
REQ-024 VALID & out_ready & no accept -> IDLE; VALID & out_ready & accept -> back-to-back, new result next cycle (ALU) or BUSY (MUL).
REQ-025 busy SHALL be 1 exactly in BUSY; in_ready=0 in BUSY.
REQ-026 flush=1 SHALL force next state IDLE, out_valid=0 next cycle, block accept that cycle; output data regs keep last value.
REQ-027 Simultaneous flush and in_valid: op dropped, not accepted.

Reset
REQ-028 rst low SHALL immediately force IDLE, out_valid=0, busy=0, alu_out=0, rs2_out=0, br_en=0, iteration counter=0.
REQ-029 rst asserted during BUSY SHALL abort multiply; no result after release.
REQ-030 in_ready SHALL be 0 while rst low; 1 in first cycle after release with flush=0.

Verification
REQ-031 ALU add, rs1_sel=0 rs1_data=5, alumux2_sel=0 imm=7, out_ready=1 -> out_valid at t+1, alu_out=12.
REQ-032 rs1_sel=2, fwd slice1=0x10, rs2_sel=1, fwd slice0=0x10, cmpop=beq, sub -> alu_out=0, br_en=1, rs2_out=0x10.
REQ-033 mulh rs1=0xFFFFFFFF, rs2=0xFFFFFFFF (XLEN=32) -> busy 32 cycles, out_valid at t+33, alu_out=0; mulhu same -> 0xFFFFFFFE.
REQ-034 ALU result with out_ready=0 for 5 cycles -> outputs stable, in_ready=0; out_ready=1 plus in_valid -> back-to-back accept.
REQ-035 flush at cycle 10 of MUL -> busy=0, out_valid=0 next cycle; following ALU op completes normally.
REQ-036 rst low mid-BUSY -> all outputs zero immediately; XLEN=16, NFWD=3 regression repeats REQ-031..033 scaled.

Source files
------------

// File: rtl/exe_stage_mc.sv
// exe_stage_mc: single-issue execute stage with a multi-cycle multiplier.
//
// Purpose
//   Resolves operand forwarding and ALU/compare muxes when an op is accepted.
//   ALU ops produce a registered result one cycle after accept. MUL ops run a
//   radix-2 shift-add on operand magnitudes (one multiplier bit per cycle,
//   XLEN iterations) and then fix the sign with a 2*XLEN-bit negate.
//
// Handshake
//   A transfer happens on a rising edge where valid and ready are both 1.
//   Upstream: in_valid/in_ready. Downstream: out_valid/out_ready. out_valid
//   stays 1 and output data stays stable until out_ready is seen high.
//   flush kills a held or in-flight op and blocks accept in the same cycle.
//
// Ports
//   clk, rst                  clock, asynchronous active-low reset
//   in_valid, in_ready        upstream handshake
//   op, cmpop                 operation select, branch compare code
//   rs1_sel, rs2_sel          0 = regfile, k = fwd_data slice k-1
//   alumux1_sel, alumux2_sel  ALU operand a: rs1/pc, operand b: imm/rs2
//   cmp_sel                   compare operand b: rs2/imm
//   rs1_data, rs2_data, pc, imm, fwd_data   operand sources
//   flush                     synchronous kill
//   out_valid, out_ready      downstream handshake
//   alu_out, rs2_out, br_en   result, forwarded rs2, branch decision
//   busy                      multiplier iterating
//   dbg_state                 current FSM state (IDLE=0, BUSY=1, VALID=2)
module exe_stage_mc #(
  parameter int XLEN = 32,
  parameter int NFWD = 2,
  localparam int SW = $clog2(NFWD + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           op,
  input  logic [2:0]           cmpop,
  input  logic [SW-1:0]        rs1_sel,
  input  logic [SW-1:0]        rs2_sel,
  input  logic                 alumux1_sel,
  input  logic                 alumux2_sel,
  input  logic                 cmp_sel,
  input  logic [XLEN-1:0]      rs1_data,
  input  logic [XLEN-1:0]      rs2_data,
  input  logic [XLEN-1:0]      pc,
  input  logic [XLEN-1:0]      imm,
  input  logic [NFWD*XLEN-1:0] fwd_data,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      alu_out,
  output logic [XLEN-1:0]      rs2_out,
  output logic                 br_en,
  output logic                 busy,
  output logic [1:0]           dbg_state
);

  localparam int SHW = $clog2(XLEN);
  localparam int CW  = $clog2(XLEN);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    VALID = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic            accept;
  logic [XLEN-1:0] rs1_fwd, rs2_fwd;
  logic [XLEN-1:0] alu_a, alu_b, cmp_b, alu_res;
  logic [SHW-1:0]  shamt;
  logic            cmp_res;

  // multiplier state
  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] mcand, acc, acc_nx, prod;
  logic [XLEN-1:0]   mplier;
  logic              neg_r, hi_r;
  logic              mul_last;
  logic [XLEN-1:0]   mul_res;

  // MUL operand signedness and magnitudes
  logic            signed_a, signed_b, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;

  // ---------------------------------------------------------------------
  // Forwarding: out-of-range selects fall back to the regfile value.
  // ---------------------------------------------------------------------
  always_comb begin
    rs1_fwd = rs1_data;
    rs2_fwd = rs2_data;
    for (int k = 1; k <= NFWD; k++) begin
      if (rs1_sel == SW'(k)) rs1_fwd = fwd_data[(k-1)*XLEN +: XLEN];
      if (rs2_sel == SW'(k)) rs2_fwd = fwd_data[(k-1)*XLEN +: XLEN];
    end
  end

  // ---------------------------------------------------------------------
  // ALU and branch compare
  // ---------------------------------------------------------------------
  always_comb begin
    alu_a = alumux1_sel ? pc : rs1_fwd;
    alu_b = alumux2_sel ? rs2_fwd : imm;
    cmp_b = cmp_sel ? imm : rs2_fwd;
    shamt = alu_b[SHW-1:0];
    unique case (op[2:0])
      3'd0:    alu_res = alu_a + alu_b;
      3'd1:    alu_res = alu_a << shamt;
      3'd2:    alu_res = $unsigned($signed(alu_a) >>> shamt);
      3'd3:    alu_res = alu_a - alu_b;
      3'd4:    alu_res = alu_a ^ alu_b;
      3'd5:    alu_res = alu_a >> shamt;
      3'd6:    alu_res = alu_a | alu_b;
      default: alu_res = alu_a & alu_b;
    endcase
    case (cmpop)
      3'b000:  cmp_res = (rs1_fwd == cmp_b);
      3'b001:  cmp_res = (rs1_fwd != cmp_b);
      3'b100:  cmp_res = ($signed(rs1_fwd) <  $signed(cmp_b));
      3'b101:  cmp_res = ($signed(rs1_fwd) >= $signed(cmp_b));
      3'b110:  cmp_res = (rs1_fwd <  cmp_b);
      3'b111:  cmp_res = (rs1_fwd >= cmp_b);
      default: cmp_res = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------
  // MUL setup. op[1:0]: 00 mul, 01 mulh, 10 mulhsu, 11 mulhu. The low half
  // is the same for any signedness, so plain mul uses the signed path.
  // ---------------------------------------------------------------------
  always_comb begin
    signed_a = (op[1:0] != 2'b11);
    signed_b = (op[1] == 1'b0);
    a_neg    = signed_a & rs1_fwd[XLEN-1];
    b_neg    = signed_b & rs2_fwd[XLEN-1];
    a_mag    = a_neg ? (-rs1_fwd) : rs1_fwd;
    b_mag    = b_neg ? (-rs2_fwd) : rs2_fwd;
  end

  // Final iteration's partial sum is folded in here so the result can be
  // registered on the same edge the FSM leaves BUSY.
  always_comb begin
    mul_last = (cnt == CW'(XLEN - 1));
    acc_nx   = acc + (mplier[0] ? mcand : '0);
    prod     = neg_r ? (-acc_nx) : acc_nx;
    mul_res  = hi_r ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
  end

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = (state_q == VALID);
    busy      = (state_q == BUSY);
    dbg_state = state_q;

    // rst gates in_ready so nothing looks acceptable while held in reset.
    in_ready = rst & ~flush &
               ((state_q == IDLE) | ((state_q == VALID) & out_ready));
    accept   = in_valid & in_ready;

    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) state_d = op[3] ? BUSY : VALID;
        end
        BUSY: begin
          if (mul_last) state_d = VALID;
        end
        VALID: begin
          if (out_ready) begin
            if (accept) state_d = op[3] ? BUSY : VALID;
            else        state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Datapath registers. Output registers only change on accept (ALU) or on
  // the last multiply iteration, so they hold while out_ready is low and
  // keep their last value across a flush.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_out <= '0;
      rs2_out <= '0;
      br_en   <= 1'b0;
      cnt     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      neg_r   <= 1'b0;
      hi_r    <= 1'b0;
    end else if (accept) begin
      rs2_out <= rs2_fwd;
      if (!op[3]) begin
        alu_out <= alu_res;
        br_en   <= cmp_res;
      end else begin
        mcand  <= {{XLEN{1'b0}}, a_mag};
        mplier <= b_mag;
        acc    <= '0;
        cnt    <= '0;
        neg_r  <= a_neg ^ b_neg;
        hi_r   <= (op[1:0] != 2'b00);
      end
    end else if (state_q == BUSY && !flush) begin
      acc    <= acc_nx;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (mul_last) begin
        alu_out <= mul_res;
        br_en   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_exe_stage_mc.sv
// tb_exe_stage_mc: scoreboard bench for exe_stage_mc.
// Two instances are built: dut_a (XLEN=32, NFWD=2) and dut_b (XLEN=16,
// NFWD=3). cfg selects which one receives in_valid and is observed; the
// other idles. Expected results come from a plain-arithmetic model (64-bit
// integer math masked to the configured width) and are queued with the
// cycle at which the result must first appear.
module tb_exe_stage_mc;

  localparam int EW = 97; // {first_valid_cycle[31:0], result[31:0], rs2[31:0], br}

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        cfg;
  logic        in_valid_s;
  logic [3:0]  op;
  logic [2:0]  cmpop;
  logic [1:0]  rs1_sel, rs2_sel;
  logic        alumux1_sel, alumux2_sel, cmp_sel;
  logic [31:0] rs1_d, rs2_d, pc_d, imm_d;
  logic [31:0] fwd [3];
  logic        flush;
  logic        out_ready;
  int          rdy_mode; // 0 random, 1 always ready, 2 never ready

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [EW-1:0] exp_q[$];

  // dut_a wires
  logic        a_in_ready, a_out_valid, a_br, a_busy;
  logic [31:0] a_alu, a_rs2;
  logic [1:0]  a_state;
  // dut_b wires
  logic        b_in_ready, b_out_valid, b_br, b_busy;
  logic [15:0] b_alu, b_rs2;
  logic [1:0]  b_state;

  exe_stage_mc #(.XLEN(32), .NFWD(2)) dut_a (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_s & ~cfg), .in_ready(a_in_ready),
    .op(op), .cmpop(cmpop), .rs1_sel(rs1_sel), .rs2_sel(rs2_sel),
    .alumux1_sel(alumux1_sel), .alumux2_sel(alumux2_sel), .cmp_sel(cmp_sel),
    .rs1_data(rs1_d), .rs2_data(rs2_d), .pc(pc_d), .imm(imm_d),
    .fwd_data({fwd[1], fwd[0]}), .flush(flush),
    .out_valid(a_out_valid), .out_ready(out_ready),
    .alu_out(a_alu), .rs2_out(a_rs2), .br_en(a_br), .busy(a_busy),
    .dbg_state(a_state)
  );

  exe_stage_mc #(.XLEN(16), .NFWD(3)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_s & cfg), .in_ready(b_in_ready),
    .op(op), .cmpop(cmpop), .rs1_sel(rs1_sel), .rs2_sel(rs2_sel),
    .alumux1_sel(alumux1_sel), .alumux2_sel(alumux2_sel), .cmp_sel(cmp_sel),
    .rs1_data(rs1_d[15:0]), .rs2_data(rs2_d[15:0]), .pc(pc_d[15:0]),
    .imm(imm_d[15:0]),
    .fwd_data({fwd[2][15:0], fwd[1][15:0], fwd[0][15:0]}), .flush(flush),
    .out_valid(b_out_valid), .out_ready(out_ready),
    .alu_out(b_alu), .rs2_out(b_rs2), .br_en(b_br), .busy(b_busy),
    .dbg_state(b_state)
  );

  // observed instance
  logic        in_ready_m, out_valid_m, br_m, busy_m;
  logic [31:0] alu_m, rs2_m;
  always_comb begin
    in_ready_m  = cfg ? b_in_ready  : a_in_ready;
    out_valid_m = cfg ? b_out_valid : a_out_valid;
    br_m        = cfg ? b_br        : a_br;
    busy_m      = cfg ? b_busy      : a_busy;
    alu_m       = cfg ? {16'h0, b_alu} : a_alu;
    rs2_m       = cfg ? {16'h0, b_rs2} : a_rs2;
  end

  function automatic int cur_w();
    return cfg ? 16 : 32;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (cfg=%0d cycle=%0d)", name, act, req, cfg, cyc);
    end
  endtask

  // ---------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------
  function automatic longint sx(input logic [63:0] v, input int w);
    longint t;
    t = longint'(v << (64 - w));
    return t >>> (64 - w);
  endfunction

  function automatic logic [EW-1:0] model(
    input int w, input int nf, input int t,
    input logic [3:0] o, input logic [2:0] co,
    input logic [1:0] s1, input logic [1:0] s2,
    input logic m1, input logic m2, input logic cs,
    input logic [31:0] r1, input logic [31:0] r2,
    input logic [31:0] p, input logic [31:0] im,
    input logic [31:0] f0, input logic [31:0] f1, input logic [31:0] f2);
    logic [63:0] mask, r1f, r2f, a, b, c, res, ea, eb, pr;
    logic [31:0] fsel [3];
    int sh, lat;
    logic br;
    fsel[0] = f0; fsel[1] = f1; fsel[2] = f2;
    mask = (64'd1 << w) - 64'd1;
    r1f = 64'(r1);
    r2f = 64'(r2);
    if (s1 != 0 && int'(s1) <= nf) r1f = 64'(fsel[s1 - 1]);
    if (s2 != 0 && int'(s2) <= nf) r2f = 64'(fsel[s2 - 1]);
    r1f &= mask;
    r2f &= mask;
    br  = 1'b0;
    if (!o[3]) begin
      a  = (m1 ? 64'(p) : r1f) & mask;
      b  = (m2 ? r2f : 64'(im)) & mask;
      sh = int'(b % 64'(w));
      case (o[2:0])
        3'd0: res = a + b;
        3'd1: res = a << sh;
        3'd2: res = sx(a, w) >>> sh;
        3'd3: res = a - b;
        3'd4: res = a ^ b;
        3'd5: res = a >> sh;
        3'd6: res = a | b;
        default: res = a & b;
      endcase
      res &= mask;
      c = cs ? (64'(im) & mask) : r2f;
      case (co)
        3'b000: br = (r1f == c);
        3'b001: br = (r1f != c);
        3'b100: br = (sx(r1f, w) <  sx(c, w));
        3'b101: br = (sx(r1f, w) >= sx(c, w));
        3'b110: br = (r1f <  c);
        3'b111: br = (r1f >= c);
        default: br = 1'b0;
      endcase
      lat = 1;
    end else begin
      // full 2w-bit product fits in 64 bits for w <= 32
      ea = (o[1:0] != 2'b11) ? 64'(sx(r1f, w)) : r1f;
      eb = (o[1] == 1'b0)    ? 64'(sx(r2f, w)) : r2f;
      pr = ea * eb;
      res = (o[1:0] == 2'b00) ? (pr & mask) : ((pr >> w) & mask);
      lat = w + 1;
    end
    return {32'(t + lat), res[31:0], r2f[31:0], br};
  endfunction

  // ---------------------------------------------------------------------
  // Drivers
  // ---------------------------------------------------------------------
  initial begin
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0: out_ready = ($urandom_range(0, 3) != 0);
        1: out_ready = 1'b1;
        default: out_ready = 1'b0;
      endcase
    end
  end

  task automatic send(input logic [3:0] o, input logic [2:0] co,
                      input logic [1:0] s1, input logic [1:0] s2,
                      input logic m1, input logic m2, input logic cs,
                      input logic [31:0] r1, input logic [31:0] r2,
                      input logic [31:0] p, input logic [31:0] im,
                      input logic [31:0] f0, input logic [31:0] f1,
                      input logic [31:0] f2);
    bit done = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      op = o; cmpop = co; rs1_sel = s1; rs2_sel = s2;
      alumux1_sel = m1; alumux2_sel = m2; cmp_sel = cs;
      rs1_d = r1; rs2_d = r2; pc_d = p; imm_d = im;
      fwd[0] = f0; fwd[1] = f1; fwd[2] = f2;
      in_valid_s = 1'b1;
      #1;
      if (in_ready_m) begin
        exp_q.push_back(model(cur_w(), cfg ? 3 : 2, cyc, o, co, s1, s2, m1, m2, cs,
                              r1, r2, p, im, f0, f1, f2));
        done = 1;
      end
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL send_timeout no accept within 300 cycles (cfg=%0d)", cfg);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid_s = 1'b0;
    end
  endtask

  task automatic drain();
    bit done = 0;
    rdy_mode = 1;
    for (int i = 0; i < 500 && !done; i++) begin
      @(negedge clk);
      in_valid_s = 1'b0;
      #3;
      if (exp_q.size() == 0 && !out_valid_m) done = 1;
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL drain_timeout pending=%0d required=0", exp_q.size());
    end
  endtask

  task automatic chk_zero_outs(input string name);
    chk({name, "_out_valid"}, out_valid_m, 0);
    chk({name, "_busy"},      busy_m, 0);
    chk({name, "_alu_out"},   alu_m, 0);
    chk({name, "_rs2_out"},   rs2_m, 0);
    chk({name, "_br_en"},     br_m, 0);
    chk({name, "_in_ready"},  in_ready_m, 0);
  endtask

  // ---------------------------------------------------------------------
  // Monitor / scoreboard
  // ---------------------------------------------------------------------
  initial begin
    logic [EW-1:0] cur;
    bit holding;
    holding = 0;
    cur = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        holding = 0;
      end else if (out_valid_m) begin
        if (!holding) begin
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_out alu_out=%0h required=no output", alu_m);
          end else begin
            cur = exp_q.pop_front();
            holding = 1;
            chk("first_valid_cycle", 128'(cyc), 128'(cur[96:65]));
          end
        end
        if (holding) chk("result", {alu_m, rs2_m, br_m}, cur[64:0]);
        if (out_ready) holding = 0;
      end else if (holding) begin
        total++; bad++;
        $display("FAIL result_dropped out_valid=0 required=1");
        holding = 0;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Test sequence for the selected instance
  // ---------------------------------------------------------------------
  task automatic run_cfg();
    int w;
    logic [31:0] ones;
    w = cur_w();
    ones = 32'hFFFF_FFFF;

    // reset state
    @(negedge clk);
    rst = 1'b0;
    in_valid_s = 1'b0;
    #1;
    chk_zero_outs("reset");
    idle(2);
    rst = 1'b1;
    #1;
    chk("in_ready_after_reset", in_ready_m, 1);

    // add: 5 + imm 7
    rdy_mode = 1;
    send(4'd0, 3'b010, 2'd0, 2'd0, 0, 0, 0, 32'd5, 32'd0, 32'd0, 32'd7, 0, 0, 0);
    // sub of two forwarded 0x10, beq against forwarded rs2
    send(4'd3, 3'b000, 2'd2, 2'd1, 0, 1, 0, 32'd1, 32'd2, 32'd0, 32'd0,
         32'h10, 32'h10, 32'h33);
    idle(1);
    drain();

    // mulh -1 * -1 and mulhu all-ones, with busy window checks
    for (int k = 0; k < 2; k++) begin
      send(k == 0 ? 4'b1001 : 4'b1011, 3'b000, 2'd0, 2'd0, 0, 0, 0,
           ones, ones, 32'd0, 32'd0, 0, 0, 0);
      for (int i = 0; i < w; i++) begin
        @(negedge clk);
        in_valid_s = 1'b0;
        #1;
        chk("busy_window", busy_m, 1);
        chk("in_ready_busy", in_ready_m, 0);
      end
      @(negedge clk);
      #1;
      chk("busy_end", busy_m, 0);
      drain();
    end
    // mulhsu with most-negative rs1
    send(4'b1010, 3'b000, 2'd0, 2'd0, 0, 0, 0, 32'(1) << (w - 1), ones,
         32'd0, 32'd0, 0, 0, 0);
    drain();

    // backpressure: hold for 5 cycles, then back-to-back accept
    rdy_mode = 2;
    send(4'd4, 3'b110, 2'd0, 2'd0, 1, 1, 1, 32'h1234, 32'h0F0F, 32'h5555,
         32'h4321, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid_s = 1'b0;
      #1;
      chk("hold_out_valid", out_valid_m, 1);
      chk("hold_in_ready", in_ready_m, 0);
    end
    rdy_mode = 1;
    send(4'd2, 3'b100, 2'd3, 2'd0, 0, 0, 1, 32'h8000_8000, 32'd3, 32'd0,
         32'd3, 32'h9, 32'hA, 32'hFFFF_FFF0);
    drain();

    // flush on the 10th busy cycle of a multiply
    send(4'b1000, 3'b000, 2'd0, 2'd0, 0, 0, 0, 32'd1234, 32'd77, 0, 0, 0, 0, 0);
    idle(9);
    @(negedge clk);
    flush = 1'b1;
    void'(exp_q.pop_back());
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("flush_busy", busy_m, 0);
    chk("flush_out_valid", out_valid_m, 0);
    chk("flush_in_ready", in_ready_m, 1);
    send(4'd6, 3'b001, 2'd0, 2'd0, 0, 0, 0, 32'h00F0, 32'h0F00, 0, 32'h000F, 0, 0, 0);
    drain();

    // flush together with in_valid: op must be dropped
    @(negedge clk);
    flush = 1'b1;
    in_valid_s = 1'b1;
    op = 4'd0;
    #1;
    chk("flush_blocks_accept", in_ready_m, 0);
    @(negedge clk);
    flush = 1'b0;
    in_valid_s = 1'b0;
    idle(3);
    #1;
    chk("flush_drop_no_output", out_valid_m, 0);

    // randomized traffic
    rdy_mode = 0;
    for (int n = 0; n < 120; n++) begin
      logic [3:0] o;
      if ($urandom_range(0, 3) == 0) o = {2'b10, 2'($urandom_range(0, 3))};
      else                           o = {1'b0, 3'($urandom_range(0, 7))};
      send(o, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
           2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    idle(1);
    drain();

    // reset in the middle of a multiply
    send(4'b1011, 3'b000, 2'd0, 2'd0, 0, 0, 0, 32'h1357, 32'h2468, 0, 0, 0, 0, 0);
    idle(5);
    #1;
    rst = 1'b0;
    #1;
    chk_zero_outs("reset_mid_busy");
    exp_q.delete();
    idle(2);
    rst = 1'b1;
    for (int i = 0; i < w + 4; i++) begin
      @(negedge clk);
      #1;
      chk("no_result_after_abort", out_valid_m, 0);
    end
  endtask

  initial begin
    rst = 1'b0;
    cfg = 1'b0;
    in_valid_s = 1'b0;
    op = '0; cmpop = '0; rs1_sel = '0; rs2_sel = '0;
    alumux1_sel = 1'b0; alumux2_sel = 1'b0; cmp_sel = 1'b0;
    rs1_d = '0; rs2_d = '0; pc_d = '0; imm_d = '0;
    fwd[0] = '0; fwd[1] = '0; fwd[2] = '0;
    flush = 1'b0;
    out_ready = 1'b0;
    rdy_mode = 1;
    idle(2);

    cfg = 1'b0;
    run_cfg();
    cfg = 1'b1;
    run_cfg();

    idle(2);
    chk("queue_empty_at_end", 128'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
